// File: rtl/demux3_reg.sv
// Registered 1:3 demultiplexer. One input stream is steered per word to one of
// three channels. Each channel has a one-entry holding register with a
// valid/ready handshake and an 8-bit (CW) counter of delivered words.
module demux3_reg #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CW    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_sel,
   output logic [2:0]       out_valid,
   input  logic [2:0]       out_ready,
   output logic [WIDTH-1:0] out_data0,
   output logic [WIDTH-1:0] out_data1,
   output logic [WIDTH-1:0] out_data2,
   output logic [CW-1:0]    cnt0,
   output logic [CW-1:0]    cnt1,
   output logic [CW-1:0]    cnt2
);

   logic [1:0]       dst;
   logic [2:0]       drain;
   logic [2:0]       load;
   logic             dst_free;
   logic             accept;
   logic [WIDTH-1:0] data_q [3];
   logic [CW-1:0]    cnt_q  [3];

   // Destination decode, handshake and per-channel load enables.
   always_comb begin
      dst      = (in_sel == 2'd3) ? 2'd2 : in_sel;
      drain    = out_valid & out_ready;
      dst_free = 1'b0;
      unique case (dst)
         2'd0:    dst_free = !out_valid[0] || out_ready[0];
         2'd1:    dst_free = !out_valid[1] || out_ready[1];
         default: dst_free = !out_valid[2] || out_ready[2];
      endcase
      // in_ready deliberately does not depend on in_valid.
      in_ready = !reset && dst_free;
      accept   = in_valid && in_ready;
      load     = '0;
      for (int k = 0; k < 3; k++) begin
         load[k] = accept && (dst == 2'(k));
      end
   end

   // Holding registers, valid flags and delivered-word counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= '0;
         for (int k = 0; k < 3; k++) begin
            data_q[k] <= '0;
            cnt_q[k]  <= '0;
         end
      end else begin
         for (int k = 0; k < 3; k++) begin
            // A same-cycle drain and load keeps the channel valid.
            if (load[k]) begin
               data_q[k]    <= in_data;
               out_valid[k] <= 1'b1;
            end else if (drain[k]) begin
               out_valid[k] <= 1'b0;
            end
            if (drain[k]) begin
               cnt_q[k] <= cnt_q[k] + 1'b1;
            end
         end
      end
   end

   assign out_data0 = data_q[0];
   assign out_data1 = data_q[1];
   assign out_data2 = data_q[2];
   assign cnt0      = cnt_q[0];
   assign cnt1      = cnt_q[1];
   assign cnt2      = cnt_q[2];

endmodule
